// File: rtl/gobang_pkg.sv
// Shared constants, state/result encodings and board-index helper for the gobang turn sequencer.
package gobang_pkg;

  localparam int BOARD_N = 15;
  localparam int CELLS   = BOARD_N * BOARD_N;
  localparam int IDX_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_HUMAN = 3'd1,
    S_CHECK_H    = 3'd2,
    S_JUDGE_H    = 3'd3,
    S_RUN_AI     = 3'd4,
    S_JUDGE_A    = 3'd5,
    S_OVER       = 3'd6,
    S_ERROR      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE  = 2'b00,
    RES_HUMAN = 2'b01,
    RES_AI    = 2'b10,
    RES_DRAW  = 2'b11
  } result_t;

  // Row-major cell index; out-of-range coordinates still fit in 8 bits (max 240).
  function automatic logic [IDX_W-1:0] cell_index(input logic [3:0] x, input logic [3:0] y);
    return ({4'd0, y} * 8'(BOARD_N)) + {4'd0, x};
  endfunction

endpackage

// File: rtl/gobang_cell_check.sv
// Combinational legality check for one board coordinate: on the board and empty on both bitmaps.
module gobang_cell_check
  import gobang_pkg::*;
(
  input  logic [3:0]       x,
  input  logic [3:0]       y,
  input  logic [CELLS-1:0] human_board,
  input  logic [CELLS-1:0] ai_board,
  output logic [IDX_W-1:0] index,
  output logic             legal
);

  logic in_range;
  logic occupied;

  always_comb begin
    index    = cell_index(x, y);
    in_range = (x < 4'(BOARD_N)) && (y < 4'(BOARD_N));
    occupied = 1'b0;
    // Only look at the bitmaps when the index is known to be inside them.
    if (in_range) begin
      occupied = human_board[index] | ai_board[index];
    end
    legal = in_range && !occupied;
  end

endmodule

// File: rtl/gobang_turn_ctrl.sv
// Turn sequencer for 15x15 gobang: owns both boards, validates moves, drives aiGo, declares win/draw.
// Optional AI search watchdog enabled by defining GOBANG_AI_WATCHDOG_EN.
//
// Handshakes: a human move transfers on a cycle where move_valid && move_ready;
// ai_enable is a level held through RUN_AI and the AI move transfers on the cycle
// ai_finish is sampled high while ai_enable is high. new_game overrides both.
module gobang_turn_ctrl
  import gobang_pkg::*;
#(
  parameter int AI_TIMEOUT = 1000000,
  parameter int WD_W       = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [3:0]       move_x,
  input  logic [3:0]       move_y,
  output logic             move_ready,
  output logic             move_reject,
  output logic             ai_enable,
  input  logic             ai_finish,
  input  logic [3:0]       ai_x,
  input  logic [3:0]       ai_y,
  input  logic             hm_win,
  input  logic             ai_win,
  output logic [CELLS-1:0] human_board,
  output logic [CELLS-1:0] ai_board,
  output logic [7:0]       move_count,
  output logic [1:0]       result,
  output logic [2:0]       fsm_state
);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       hx;
  logic [3:0]       hy;
  logic [3:0]       chk_x;
  logic [3:0]       chk_y;
  logic [IDX_W-1:0] chk_idx;
  logic             chk_legal;
  logic             board_full;
  logic             human_commit;
  logic             ai_commit;
  logic             wd_expired;

  // The checker serves the latched human move, except while the AI owns the turn.
  always_comb begin
    chk_x = hx;
    chk_y = hy;
    if (state == S_RUN_AI) begin
      chk_x = ai_x;
      chk_y = ai_y;
    end
  end

  gobang_cell_check u_cell_check (
    .x           (chk_x),
    .y           (chk_y),
    .human_board (human_board),
    .ai_board    (ai_board),
    .index       (chk_idx),
    .legal       (chk_legal)
  );

  assign board_full   = (move_count == 8'(CELLS));
  assign human_commit = (state == S_CHECK_H) && chk_legal && !new_game;
  assign ai_commit    = (state == S_RUN_AI) && ai_finish && chk_legal && !new_game;

`ifdef GOBANG_AI_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside RUN_AI, so every search starts counting from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state != S_RUN_AI) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expired = (state == S_RUN_AI) && (wd_cnt == WD_W'(AI_TIMEOUT - 1));
`else
  localparam bit unused_wd_cfg = (AI_TIMEOUT > 0) && (WD_W > 0);
  assign wd_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; new_game beats every other event in the same cycle.
  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state_nxt = S_WAIT_HUMAN;
        end
        S_WAIT_HUMAN: begin
          if (move_valid) state_nxt = S_CHECK_H;
        end
        S_CHECK_H: begin
          state_nxt = chk_legal ? S_JUDGE_H : S_WAIT_HUMAN;
        end
        S_JUDGE_H: begin
          if (hm_win || board_full) state_nxt = S_OVER;
          else                      state_nxt = S_RUN_AI;
        end
        S_RUN_AI: begin
          if (ai_finish)       state_nxt = chk_legal ? S_JUDGE_A : S_ERROR;
          else if (wd_expired) state_nxt = S_ERROR;
        end
        S_JUDGE_A: begin
          if (ai_win || board_full) state_nxt = S_OVER;
          else                      state_nxt = S_WAIT_HUMAN;
        end
        S_OVER:  state_nxt = S_OVER;
        S_ERROR: state_nxt = S_ERROR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    move_ready  = 1'b0;
    move_reject = 1'b0;
    ai_enable   = 1'b0;
    fsm_state   = state;
    case (state)
      S_WAIT_HUMAN: move_ready  = 1'b1;
      S_CHECK_H:    move_reject = !chk_legal && !new_game;
      S_RUN_AI:     ai_enable   = 1'b1;
      default: ;
    endcase
  end

  // Latched human move: captured on the accepting handshake only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hx <= '0;
      hy <= '0;
    end else if ((state == S_WAIT_HUMAN) && move_valid && !new_game) begin
      hx <= move_x;
      hy <= move_y;
    end
  end

  // Boards only change on a committed move, so humanIn is stable during a search.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      human_board <= '0;
      ai_board    <= '0;
      move_count  <= '0;
      result      <= RES_NONE;
    end else if (new_game) begin
      human_board <= '0;
      ai_board    <= '0;
      move_count  <= '0;
      result      <= RES_NONE;
    end else begin
      if (human_commit) begin
        human_board[chk_idx] <= 1'b1;
      end
      if (ai_commit) begin
        ai_board[chk_idx] <= 1'b1;
      end
      if ((human_commit || ai_commit) && !board_full) begin
        move_count <= move_count + 8'd1;
      end
      case (state)
        S_IDLE: begin
          if (start) result <= RES_NONE;
        end
        S_JUDGE_H: begin
          if (hm_win)          result <= RES_HUMAN;
          else if (board_full) result <= RES_DRAW;
        end
        S_JUDGE_A: begin
          if (ai_win)          result <= RES_AI;
          else if (board_full) result <= RES_DRAW;
        end
        default: ;
      endcase
    end
  end

endmodule
